// File: rtl/lalu_pkg.sv
// lalu_pkg: shared fetch widths and the buffered fetch entry layout
package lalu_pkg;
  localparam int ADDR_W = 6;
  localparam int INSTR_W = 16;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: register FIFO holding fetched words, with flush taking priority over push/pop
module fetch_skid_fifo
  import lalu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  fetch_entry_t                 i_data,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_rd_nxt, w_wr_nxt;
  assign w_rd_nxt = (r_rd == PW'(DEPTH-1)) ? '0 : r_rd + 1'b1;
  assign w_wr_nxt = (r_wr == PW'(DEPTH-1)) ? '0 : r_wr + 1'b1;
  assign o_head   = r_mem[r_rd];
  assign o_count  = r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_count <= '0;
      r_rd    <= r_wr;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= w_wr_nxt;
      end
      if (i_pop) r_rd <= w_rd_nxt;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: issues PC to a 1-cycle ROM, buffers returned words, and throttles the PC
module instr_fetch
  import lalu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               jmp,
  output logic               pc_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = CW + 1;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_req_pc;
  logic [CW-1:0]     w_count;
  logic              w_pop, w_push, w_issue;
  fetch_entry_t      w_head;
  assign instr_valid = (w_count != '0);
  assign w_pop       = instr_valid & instr_ready;
  assign w_push      = r_inflight & !jmp;
  // Reserve a slot for the word already in flight so the FIFO can never overflow
  assign w_issue     = !jmp & ((OW'(w_count) + OW'(r_inflight) - OW'(w_pop)) < OW'(DEPTH));
  assign pc_en       = rst & (w_issue | jmp);
  assign imem_addr   = pc;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 1'b0;
      r_req_pc   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_req_pc <= pc;
    end
  end
  fetch_skid_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (jmp),
    .i_data  ('{instr: imem_data, pc: r_req_pc}),
    .o_head  (w_head),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of streaming, back-pressure, jumps, wrap and reset
module tb_instr_fetch;
  logic        clk, rst, jmp, pc_en, instr_valid, instr_ready;
  logic [5:0]  pc, imem_addr, instr_pc, tgt;
  logic [15:0] imem_data, instr;
  int          n_vec = 0;
  int          n_err = 0;
  instr_fetch #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .jmp         (jmp),
    .pc_en       (pc_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst)
    if (!rst) pc <= '0;
    else if (pc_en) pc <= jmp ? tgt : pc + 6'd1;
  always @(posedge clk) imem_data <= 16'hA000 + 16'(imem_addr);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst) check("no_ovf", 32'(dut.w_push & ~dut.w_pop & (dut.w_count == 2'd2)), 0);
  initial begin
    int wrap_pc [4] = '{62, 63, 0, 1};
    rst = 1'b0; jmp = 1'b0; instr_ready = 1'b1; tgt = '0;
    repeat (2) cyc();
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_pc_en", 32'(pc_en), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_instr_pc", 32'(instr_pc), 0);
    rst = 1'b1;
    #1;
    check("first_pc_en", 32'(pc_en), 1);
    check("first_addr", 32'(imem_addr), 0);
    cyc();
    check("lat_valid", 32'(instr_valid), 0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("stream_valid", 32'(instr_valid), 1);
      check("stream_instr", 32'(instr), 32'('hA000 + k));
      check("stream_pc", 32'(instr_pc), 32'(k));
      check("stream_pc_en", 32'(pc_en), 1);
    end
    instr_ready = 1'b0;
    #1;
    check("bp_pc_en0", 32'(pc_en), 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("bp_valid", 32'(instr_valid), 1);
      check("bp_instr", 32'(instr), 'hA005);
      check("bp_pc", 32'(instr_pc), 5);
      check("bp_pc_en", 32'(pc_en), 0);
    end
    check("bp_pc_hold", 32'(pc), 7);
    instr_ready = 1'b1;
    #1;
    check("drain_pc_en", 32'(pc_en), 1);
    for (int k = 6; k < 10; k++) begin
      cyc();
      check("drain_valid", 32'(instr_valid), 1);
      check("drain_instr", 32'(instr), 32'('hA000 + k));
      check("drain_pc", 32'(instr_pc), 32'(k));
    end
    instr_ready = 1'b0;
    cyc();
    check("jf_head", 32'(instr), 'hA009);
    check("jf_pc_en0", 32'(pc_en), 0);
    jmp = 1'b1; tgt = 6'h20;
    #1;
    check("jmp_pc_en", 32'(pc_en), 1);
    cyc();
    jmp = 1'b0;
    check("jmp_flush", 32'(instr_valid), 0);
    instr_ready = 1'b1;
    #1;
    check("jmp_issue_en", 32'(pc_en), 1);
    check("jmp_issue_addr", 32'(imem_addr), 'h20);
    cyc();
    check("jmp_lat", 32'(instr_valid), 0);
    cyc();
    check("jmp_tgt_valid", 32'(instr_valid), 1);
    check("jmp_tgt_instr", 32'(instr), 'hA020);
    check("jmp_tgt_pc", 32'(instr_pc), 'h20);
    cyc();
    check("jmp_next_instr", 32'(instr), 'hA021);
    jmp = 1'b1; tgt = 6'h30;
    #1;
    check("jpop_valid", 32'(instr_valid), 1);
    check("jpop_instr", 32'(instr), 'hA021);
    cyc();
    jmp = 1'b0;
    check("jpop_flush", 32'(instr_valid), 0);
    cyc();
    check("jpop_lat", 32'(instr_valid), 0);
    cyc();
    check("jpop_tgt_valid", 32'(instr_valid), 1);
    check("jpop_tgt_instr", 32'(instr), 'hA030);
    check("jpop_tgt_pc", 32'(instr_pc), 'h30);
    jmp = 1'b1; tgt = 6'h3E;
    cyc();
    jmp = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("wrap_valid", 32'(instr_valid), 1);
      check("wrap_pc", 32'(instr_pc), 32'(wrap_pc[i]));
      check("wrap_instr", 32'(instr), 32'('hA000 + wrap_pc[i]));
    end
    instr_ready = 1'b0;
    cyc();
    check("mr_pre_valid", 32'(instr_valid), 1);
    rst = 1'b0;
    #1;
    check("mr_valid", 32'(instr_valid), 0);
    check("mr_pc_en", 32'(pc_en), 0);
    cyc();
    check("mr_hold_valid", 32'(instr_valid), 0);
    check("mr_hold_pc", 32'(instr_pc), 0);
    rst = 1'b1; instr_ready = 1'b1;
    #1;
    check("mr_first_en", 32'(pc_en), 1);
    check("mr_first_addr", 32'(imem_addr), 0);
    repeat (2) cyc();
    check("mr_word_valid", 32'(instr_valid), 1);
    check("mr_word_instr", 32'(instr), 'hA000);
    check("mr_word_pc", 32'(instr_pc), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
